// File: rtl/regfile_sb_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    // Index width for a register count; at least one bit so that NREG=2 still has an address.
    function automatic int addr_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_sb_score.sv
// Busy-bit scoreboard: tracks registers with a pending producer and keeps a
// registered popcount of the busy bits. Register 0 is never marked busy.
module regfile_sb_score
    import regfile_sb_pkg::*;
#(
    parameter  int NREG = DEF_NREG,
    localparam int AW   = addr_w(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_cnt
);

    logic            do_set;
    logic            do_clr;
    logic            cnt_inc;
    logic            cnt_dec;
    logic [NREG-1:0] busy_nxt;

    // Next busy vector and count delta; an issue to the index being written keeps the bit set.
    always_comb begin
        do_set   = iss_valid && (iss_rd != '0) && (int'(iss_rd) < NREG);
        do_clr   = wen && (waddr != '0) && (int'(waddr) < NREG);
        cnt_inc  = do_set && !busy[iss_rd];
        cnt_dec  = do_clr && busy[waddr] && !(do_set && (iss_rd == waddr));
        busy_nxt = busy;
        if (do_clr) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (do_set) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy bits and count; flush drops every pending producer, including a same-cycle issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy-bit scoreboard, NRD combinational read ports and a
// debug read port. Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback
// data (and a cleared busy flag) to matching read ports; the debug port never forwards.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN = DEF_XLEN,
    parameter  int NREG = DEF_NREG,
    parameter  int NRD  = DEF_NRD,
    localparam int AW   = addr_w(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [AW:0]       busy_cnt,
    input  logic [AW-1:0]     dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    regfile_sb_score #(.NREG(NREG)) u_score (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    // Data array; register 0 and out-of-range indices are never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0) && (int'(waddr) < NREG)) begin
            regs[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] d;
        logic            b;

        assign ra = rd_addr[k*AW +: AW];

        // Read mux for port k; zero in reset, for x0 and for out-of-range indices.
        always_comb begin
            d = '0;
            b = 1'b0;
            if (rst && (ra != '0) && (int'(ra) < NREG)) begin
                d = regs[ra];
                b = busy[ra];
`ifdef REGFILE_SB_BYPASS_EN
                if (wen && (waddr == ra)) begin
                    d = wdata;
                    if (!(iss_valid && (iss_rd == ra))) begin
                        b = 1'b0;
                    end
                end
`endif
            end
        end

        assign rd_data[k*XLEN +: XLEN] = d;
        assign rd_busy[k]              = b;
    end

    // Debug read always shows stored contents.
    always_comb begin
        dbg_data = '0;
        if (rst && (dbg_addr != '0) && (int'(dbg_addr) < NREG)) begin
            dbg_data = regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a behavioural model predicts reads and the
// busy count, expectations are queued when stimulus is applied and popped
// against DUT outputs. Works in both REGFILE_SB_BYPASS_EN builds.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 wen       = 1'b0;
    logic [AW-1:0]        waddr     = '0;
    logic [XLEN-1:0]      wdata     = '0;
    logic [NRD*AW-1:0]    rd_addr   = '0;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 iss_valid = 1'b0;
    logic [AW-1:0]        iss_rd    = '0;
    logic                 flush     = 1'b0;
    logic [AW:0]          busy_cnt;
    logic [AW-1:0]        dbg_addr  = '0;
    logic [XLEN-1:0]      dbg_data;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    logic [63:0]     sb_q [$];

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .busy_cnt  (busy_cnt),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input logic [63:0] v);
        sb_q.push_back(v);
    endtask

    task automatic sb_pop_check(input string tag, input logic [63:0] act);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, act);
        end else begin
            check(tag, act, sb_q.pop_front());
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int m_cnt();
        int c;
        c = 0;
        for (int i = 0; i < NREG; i++) begin
            if (m_busy[i]) c++;
        end
        return c;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wen && (int'(waddr) == a)) return wdata;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (wen && (int'(waddr) == a) && !(iss_valid && (int'(iss_rd) == a))) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // One clock edge: advance the model with the inputs presented before the edge.
    task automatic tick();
        @(posedge clk);
        if (flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else begin
            if (wen && (waddr != '0)) m_busy[waddr] = 1'b0;
            if (iss_valid && (iss_rd != '0)) m_busy[iss_rd] = 1'b1;
        end
        if (wen && (waddr != '0)) m_regs[waddr] = wdata;
        #1;
    endtask

    task automatic idle();
        wen       = 1'b0;
        iss_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic read_check(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
        dbg_addr = AW'(a);
        #1;
        sb_push(64'(exp_data(a)));
        sb_push(64'(exp_busy(a)));
        sb_push(64'(m_regs[a]));
        sb_pop_check($sformatf("rd_data%0d x%0d", p, a), 64'(rd_data[p*XLEN +: XLEN]));
        sb_pop_check($sformatf("rd_busy%0d x%0d", p, a), 64'(rd_busy[p]));
        sb_pop_check($sformatf("dbg_data x%0d", a), 64'(dbg_data));
    endtask

    task automatic cnt_check(input string tag);
        sb_push(64'(m_cnt()));
        sb_pop_check(tag, 64'(busy_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        rd_addr = {AW'(2), AW'(1)};
        dbg_addr = AW'(1);
        #3;
        cnt_check("reset busy_cnt");
        sb_push(64'd0);
        sb_pop_check("reset rd_data", 64'(rd_data));
        sb_push(64'd0);
        sb_pop_check("reset rd_busy", 64'(rd_busy));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // write x5 then read it back
        wen = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
        tick(); idle();
        read_check(0, 5);

        // x0 ignores writes and issues
        wen = 1'b1; waddr = 0; wdata = 32'h1234; iss_valid = 1'b1; iss_rd = 0;
        tick(); idle();
        read_check(0, 0);
        cnt_check("x0 busy_cnt");

        // issue x3, x7, x3 then retire x3
        iss_valid = 1'b1; iss_rd = 3; tick(); cnt_check("iss x3 cnt");
        iss_rd = 7; tick(); cnt_check("iss x7 cnt");
        iss_rd = 3; tick(); cnt_check("iss x3 again cnt");
        idle();
        wen = 1'b1; waddr = 3; wdata = 32'h33;
        tick(); idle();
        cnt_check("write x3 cnt");
        read_check(1, 3);

        // issue and write the same register in one cycle
        iss_valid = 1'b1; iss_rd = 9; wen = 1'b1; waddr = 9; wdata = 32'h55;
        tick(); idle();
        read_check(0, 9);
        cnt_check("iss+wen x9 cnt");

        // same-cycle read of a register being written
        wen = 1'b1; waddr = 4; wdata = 32'hA5A5A5A5;
        read_check(0, 4);
        tick(); idle();
        read_check(0, 4);

        // write to a busy register that is re-issued in the same cycle
        wen = 1'b1; waddr = 7; wdata = 32'h77; iss_valid = 1'b1; iss_rd = 7;
        read_check(1, 7);
        tick(); idle();
        read_check(1, 7);
        cnt_check("reissue x7 cnt");

        // random traffic
        repeat (300) begin
            wen       = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, NREG - 1));
            wdata     = $urandom();
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREG - 1));
            flush     = ($urandom_range(0, 15) == 0);
            read_check(0, (wen && $urandom_range(0, 1) == 1) ? int'(waddr) : int'($urandom_range(0, NREG - 1)));
            read_check(1, $urandom_range(0, NREG - 1));
            tick();
            cnt_check("random busy_cnt");
        end
        idle();

        // flush overrides a same-cycle issue
        flush = 1'b1; tick(); idle();
        iss_valid = 1'b1;
        iss_rd = 1; tick();
        iss_rd = 2; tick();
        iss_rd = 6; tick();
        idle();
        cnt_check("busy x1 x2 x6 cnt");
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 8;
        tick(); idle();
        cnt_check("flush cnt");
        read_check(0, 8);

        // asynchronous reset in the middle of activity
        iss_valid = 1'b1; iss_rd = 10; tick();
        iss_rd = 11; wen = 1'b1; waddr = 5; wdata = 32'hCAFE;
        rd_addr = {AW'(10), AW'(5)};
        dbg_addr = AW'(5);
        #1;
        rst = 1'b0;
        #1;
        sb_push(64'd0); sb_pop_check("mid-reset busy_cnt", 64'(busy_cnt));
        sb_push(64'd0); sb_pop_check("mid-reset rd_data", 64'(rd_data));
        sb_push(64'd0); sb_pop_check("mid-reset rd_busy", 64'(rd_busy));
        sb_push(64'd0); sb_pop_check("mid-reset dbg_data", 64'(dbg_data));
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        iss_valid = 1'b1; iss_rd = 12;
        tick(); idle();
        cnt_check("post-reset cnt");
        read_check(0, 5);
        read_check(1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 2..64; address width AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wen  in  1  writeback enable.
REQ-007 SHALL have port waddr  in  AW  writeback register index.
REQ-008 SHALL have port wdata  in  XLEN  writeback data.
REQ-009 SHALL have port rd_addr  in  NRD*AW  packed read indices; port k uses bits [k*AW +: AW].
REQ-010 SHALL have port rd_data  out  NRD*XLEN  packed read data.
REQ-011 SHALL have port rd_busy  out  NRD  per-port flag: the addressed register has a pending producer.
REQ-012 SHALL have port iss_valid  in  1  an instruction issues and will write iss_rd.
REQ-013 SHALL have port iss_rd  in  AW  destination index of the issuing instruction.
REQ-014 SHALL have port flush  in  1  drop all pending producers.
REQ-015 SHALL have port busy_cnt  out  AW+1  number of registers currently marked busy.
REQ-016 SHALL have port dbg_addr  in  AW  debug/DPI read index.
REQ-017 SHALL have port dbg_data  out  XLEN  debug read data, combinational, never bypassed.

Function
REQ-018 Register 0 SHALL read as zero on every port; writes to it are ignored; it is never busy.
REQ-019 wen=1 with waddr!=0 SHALL store wdata at the clock edge and clear busy[waddr].
REQ-020 iss_valid=1 with iss_rd!=0 SHALL set busy[iss_rd] at the clock edge.
REQ-021 iss_valid and wen to the same index in the same cycle SHALL leave the bit set (issue wins); data is still written.
REQ-022 flush=1 SHALL clear every busy bit at the edge, overriding a same-cycle issue; a same-cycle write still updates data.
REQ-023 Read ports SHALL be combinational from rd_addr; rd_busy[k] = busy[rd_addr[k]] subject to REQ-033.
REQ-024 busy_cnt SHALL be a registered count equal to the popcount of the busy bits after every edge: +1 on a new set, -1 on a clear of a set bit, 0 change for set-on-set or clear-on-clear, reload 0 on flush.
REQ-025 Out-of-range indices (>= NREG, reachable only for non-power-of-two use) SHALL read zero and be ignored on write and issue.

Reset
REQ-026 Assertion of rst SHALL asynchronously clear all registers to 0, all busy bits, and busy_cnt.
REQ-027 Reset mid-operation SHALL discard in-flight issues; the first edge after deassertion behaves as from a clean state.
REQ-028 While in reset, rd_data, rd_busy and dbg_data SHALL read 0.

Configuration
REQ-029 Macro REGFILE_SB_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 Defined: a read port whose rd_addr equals waddr (nonzero) while wen=1 SHALL return wdata and rd_busy=0 in that cycle, unless iss_valid targets the same index in the same cycle (then rd_busy stays as stored).
REQ-031 Undefined: reads SHALL return stored contents and stored busy; written data is visible from the next cycle.
REQ-032 dbg_data SHALL be unaffected by the macro.
REQ-033 Bypass-dependent read behaviour SHALL be the only difference between the two builds.

Structure
REQ-034 A shared package SHALL hold default XLEN, NREG, NRD and the clog2-derived AW helper.
REQ-035 One sub-module regfile_sb_score SHALL own the busy bits and busy_cnt; the top owns the data array and read muxing.

Verification
REQ-036 Reset, then write x5=0xDEADBEEF; next cycle read port0 x5 -> 0xDEADBEEF, busy 0.
REQ-037 wen to x0 with 0x1234 and iss_rd=0 -> x0 reads 0, busy_cnt stays 0.
REQ-038 Issue x3, x7, x3 on consecutive cycles -> busy_cnt 1,2,2; write x3 -> busy_cnt 1, rd_busy(x3)=0.
REQ-039 Same cycle iss_rd=9 and wen waddr=9 data 0x55 -> next cycle x9=0x55, busy(x9)=1, busy_cnt incremented by 1.
REQ-040 With REGFILE_SB_BYPASS_EN, wen x4=0xA5A5A5A5 and rd_addr0=4 same cycle -> rd_data0=0xA5A5A5A5, rd_busy0=0; without macro -> old value that cycle.
REQ-041 Busy x1, x2, x6 then flush with iss_rd=8 same cycle -> busy_cnt 0; assert rst mid-sequence -> all outputs 0 immediately.
